aes_host_port: RTL
==================

// Module: aes_host_port
// PURPOSE
//  Host-side byte-stream front end for the pipelined aes_128 core: collects a 32-byte frame (key, then plaintext),
//  drives the core's key/state inputs and holds them stable for the core latency, captures the 128-bit ciphertext,
//  then streams it back as 16 bytes. Sits between the external host link and aes_128, replacing direct wide-bus drive.
// PARAMETERS
//  LATENCY   21  cycles from stable aes_state/aes_key to a valid aes_out (must equal core pipeline depth; >=1)
//  CNT_W     5   width of the internal byte/latency counters (must hold max(31, LATENCY))
// PORTS
//  clk        in   1    system clock, all flops rising-edge
//  rst        in   1    asynchronous, active-low reset
//  in_data    in   8    host byte
//  in_valid   in   1    in_data valid
//  in_first   in   1    qualifies first byte of a frame (with in_valid)
//  in_ready   out  1    block accepts in_data this cycle
//  out_data   out  8    ciphertext byte
//  out_valid  out  1    out_data valid
//  out_last   out  1    marks 16th ciphertext byte
//  out_ready  in   1    host accepts out_data this cycle
//  aes_key    out  128  key to core
//  aes_state  out  128  plaintext to core
//  aes_out    in   128  ciphertext from core
//  busy       out  1    high in WAIT and UNLOAD
//  frame_err  out  1    one-cycle pulse on framing violation
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; out_last=0; out_data=0; aes_key=0; aes_state=0; busy=0; frame_err=0.
//  Transfer occurs on in_valid&in_ready (input) / out_valid&out_ready (output); either side may stall indefinitely.
//  FSM: IDLE -> LOAD -> WAIT -> UNLOAD -> IDLE.
//   IDLE: byte with in_first=1 stored, byte_cnt=1, -> LOAD. Byte with in_first=0: dropped, frame_err pulse, stay.
//   LOAD: bytes 0..15 fill aes_key, bytes 16..31 fill aes_state, MSB first (byte n -> bits [127-8n%16 -: 8]).
//    in_first=1 mid-frame: frame restarts (that byte becomes byte 0), frame_err pulse, partial data discarded.
//    After byte 31: in_ready=0, lat_cnt=0, -> WAIT.
//   WAIT: in_ready=0; aes_key/aes_state held constant; lat_cnt increments each cycle; at lat_cnt==LATENCY-1,
//    aes_out is sampled into a 128-bit capture register on the next edge, -> UNLOAD.
//   UNLOAD: out_valid=1, out_data = capture byte k (k=0 is [127:120]); out_last=1 when k==15. Data stable while
//    out_valid&!out_ready. After k==15 accepted: out_valid=0, -> IDLE, in_ready=1 next cycle.
//  aes_key/aes_state change only in LOAD; core sees them one cycle after the accepting edge.
//  Latency: last input byte accepted at cycle t -> first out_valid at t+LATENCY+1.
//  No input accepted in WAIT/UNLOAD (no overlap). in_valid ignored there, no frame_err.
//  Reset asserted mid-frame: all state returns to reset values asynchronously; partial frame and capture lost.
// CONFIGURATION
//  AES_PORT_KEYHOLD_EN defined: adds input in_keyhold (1). If in_keyhold=1 with the first byte in IDLE, frame is
//   16 bytes of plaintext only (bytes fill aes_state); aes_key keeps its last loaded value. After reset, a keyhold
//   frame uses key 0. in_keyhold sampled only with the first byte.
//  Not defined: port absent; every frame is exactly 32 bytes.
// STRUCTURE
//  Package aes_port_pkg: FSM state enum (IDLE, LOAD, WAIT, UNLOAD), FRAME_BYTES=32, BLOCK_BYTES=16, byte-index
//   to bit-slice helper function.
//  Single module; no sub-module (shift-in and shift-out are plain registers). Core instanced at top level.
// TESTING
//  Bench instantiates aes_host_port + aes_128 with LATENCY at the core's depth.
//  1 FIPS-197: key 000102..0e0f, pt 00112233..eeff, no stalls -> 16 bytes 69 c4 e0 d8 .. c5 5a, out_last on 5a,
//    first out_valid exactly LATENCY+1 cycles after byte 31.
//  2 Random in_valid/out_ready stalls (50%) on vector 1 -> identical ciphertext; out_data stable while stalled.
//  3 in_first=1 at byte 10, then full valid frame -> one frame_err pulse, ciphertext of second frame only.
//  4 Byte with in_first=0 in IDLE -> dropped, frame_err pulse; following proper frame unaffected.
//  5 rst low during byte 20 and again during UNLOAD byte 7 -> outputs at reset values; next frame correct.
//  6 (AES_PORT_KEYHOLD_EN) vector 1 frame, then 16-byte keyhold frame pt 00112233..eeff -> 69c4..c55a again.

Source files
------------

// File: rtl/aes_port_pkg.sv
// Shared types and helpers for the aes_128 host byte-stream port.
package aes_port_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } port_state_t;

   localparam int FRAME_BYTES = 32;
   localparam int BLOCK_BYTES = 16;

   // Byte n of a 128-bit block, MSB first, starts at this LSB.
   function automatic logic [6:0] byte_lsb(input logic [4:0] idx);
      return 7'd120 - {idx[3:0], 3'b000};
   endfunction

endpackage

// File: rtl/aes_host_port.sv
// Byte-stream front end for aes_128: 32-byte key+plaintext in, 16-byte ciphertext out.
// Optional AES_PORT_KEYHOLD_EN adds in_keyhold for 16-byte plaintext-only frames.
module aes_host_port
   import aes_port_pkg::*;
#(
   parameter int LATENCY = 21,
   parameter int CNT_W   = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_first,
`ifdef AES_PORT_KEYHOLD_EN
   input  logic         in_keyhold,
`endif
   output logic         in_ready,
   output logic [7:0]   out_data,
   output logic         out_valid,
   output logic         out_last,
   input  logic         out_ready,
   output logic [127:0] aes_key,
   output logic [127:0] aes_state,
   input  logic [127:0] aes_out,
   output logic         busy,
   output logic         frame_err
);

   port_state_t r_state, w_state_nxt;

   logic [CNT_W-1:0] r_byte_cnt;
   logic [CNT_W-1:0] r_lat_cnt;
   logic [3:0]       r_out_idx;
   logic [127:0]     r_key;
   logic [127:0]     r_pt;
   logic [127:0]     r_cap;
   logic             r_err;

   logic       w_acc;
   logic       w_start;
   logic       w_store;
   logic       w_err_nxt;
   logic       w_lat_done;
   logic       w_out_acc;
   logic       w_hold;
   logic [4:0] w_idx;
   logic [6:0] w_in_lsb;

`ifdef AES_PORT_KEYHOLD_EN
   assign w_hold = in_keyhold;
`else
   assign w_hold = 1'b0;
`endif

   assign in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign w_acc      = in_valid && in_ready;
   assign w_start    = w_acc && in_first;
   assign w_lat_done = (r_state == S_WAIT) &&
                       (r_lat_cnt == CNT_W'(LATENCY - 1));
   assign w_out_acc  = (r_state == S_UNLOAD) && out_ready;

   // A keyhold frame starts at byte 16 so only the plaintext half is written.
   assign w_idx    = w_start ? {w_hold, 4'd0} : r_byte_cnt[4:0];
   assign w_in_lsb = byte_lsb(w_idx);

   always_comb begin
      w_state_nxt = r_state;
      w_store     = 1'b0;
      w_err_nxt   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               if (in_first) begin
                  w_store     = 1'b1;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (w_acc) begin
               w_store   = 1'b1;
               w_err_nxt = in_first;
               if (!in_first &&
                   r_byte_cnt == CNT_W'(FRAME_BYTES - 1))
                  w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_lat_done)
               w_state_nxt = S_UNLOAD;
         end
         S_UNLOAD: begin
            if (w_out_acc && r_out_idx == 4'(BLOCK_BYTES - 1))
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byte_cnt <= '0;
         r_lat_cnt  <= '0;
         r_out_idx  <= '0;
         r_key      <= '0;
         r_pt       <= '0;
         r_cap      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_err_nxt;
         if (w_store) begin
            if (w_idx[4])
               r_pt[w_in_lsb +: 8] <= in_data;
            else
               r_key[w_in_lsb +: 8] <= in_data;
            r_byte_cnt <= CNT_W'(w_idx) + CNT_W'(1);
         end
         if (r_state == S_WAIT)
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
         else
            r_lat_cnt <= '0;
         if (w_lat_done)
            r_cap <= aes_out;
         if (r_state != S_UNLOAD)
            r_out_idx <= '0;
         else if (w_out_acc)
            r_out_idx <= r_out_idx + 4'd1;
      end
   end

   assign out_valid = (r_state == S_UNLOAD);
   assign out_last  = out_valid && (r_out_idx == 4'(BLOCK_BYTES - 1));
   assign out_data  = out_valid ? r_cap[byte_lsb({1'b0, r_out_idx}) +: 8]
                                : 8'h00;
   assign aes_key   = r_key;
   assign aes_state = r_pt;
   assign busy      = (r_state == S_WAIT) || (r_state == S_UNLOAD);
   assign frame_err = r_err;

endmodule
